// File: rtl/ycc_arb_pkg.sv
// Shared definitions for the two-requester RGB-to-YCbCr converter arbiter:
// FSM encoding, default parameters and component packing order of the pixel buses.
package ycc_arb_pkg;

    localparam int unsigned DefDsize = 16;
    localparam int unsigned DefLat   = 3;
    localparam int unsigned DefBurst = 16;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StGnt0 = 2'd1;
    localparam state_t StGnt1 = 2'd2;

    // Component slot index within a 3*DSIZE bus; slot 2 is the most significant.
    localparam int unsigned RgbRPos  = 2;
    localparam int unsigned RgbGPos  = 1;
    localparam int unsigned RgbBPos  = 0;
    localparam int unsigned YccYPos  = 2;
    localparam int unsigned YccCbPos = 1;
    localparam int unsigned YccCrPos = 0;

endpackage

// File: rtl/ycc_tag_pipe.sv
// Fixed-length delay line carrying {valid, id} tags alongside the shared converter.
// A synchronous clear wipes every stage so in-flight tags are discarded.
module ycc_tag_pipe #(
    parameter int unsigned LAT = 3,
    parameter int unsigned W   = 2
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [LAT];

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[LAT-1];

endmodule

// File: rtl/ycc_share_arb.sv
// Round-robin burst arbiter sharing one external RGB-to-YCbCr converter between two
// requesters; results are tagged with their owner and checked against cv_de_ret.
module ycc_share_arb
    import ycc_arb_pkg::*;
#(
    parameter int unsigned DSIZE = DefDsize,
    parameter int unsigned LAT   = DefLat,
    parameter int unsigned BURST = DefBurst
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3*DSIZE-1:0] req0_rgb,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3*DSIZE-1:0] req1_rgb,
    output logic               cv_de,
    output logic [DSIZE-1:0]   cv_R,
    output logic [DSIZE-1:0]   cv_G,
    output logic [DSIZE-1:0]   cv_B,
    input  logic               cv_de_ret,
    input  logic [DSIZE-1:0]   cv_Y,
    input  logic [DSIZE-1:0]   cv_Cb,
    input  logic [DSIZE-1:0]   cv_Cr,
    output logic               out_valid,
    output logic               out_id,
    output logic [3*DSIZE-1:0] out_ycc,
    output logic               err
);

    localparam int unsigned CntW  = $clog2(BURST + 1);
    localparam int unsigned MaskW = $clog2(LAT + 2);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              xfer0, xfer1, xfer, burst_done;
    logic              own_id, own_valid, other_valid;
    logic [3*DSIZE-1:0] xfer_rgb;
    logic              cv_id_q;
    logic              tag_valid, tag_id;
    logic [MaskW-1:0]  mask_q;

    assign req0_ready  = (state_q == StGnt0);
    assign req1_ready  = (state_q == StGnt1);
    assign xfer0       = req0_valid & req0_ready;
    assign xfer1       = req1_valid & req1_ready;
    assign xfer        = xfer0 | xfer1;
    assign burst_done  = xfer && (cnt_q == CntW'(BURST - 1));
    assign own_id      = (state_q == StGnt1);
    assign own_valid   = own_id ? req1_valid : req0_valid;
    assign other_valid = own_id ? req0_valid : req1_valid;
    assign xfer_rgb    = xfer1 ? req1_rgb : req0_rgb;

    // rr_q names the requester favoured on the next contended grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            StIdle: begin
                if (req1_valid && (!req0_valid || rr_q)) begin
                    state_d = StGnt1;
                    cnt_d   = '0;
                    rr_d    = 1'b0;
                end else if (req0_valid) begin
                    state_d = StGnt0;
                    cnt_d   = '0;
                    rr_d    = 1'b1;
                end
            end
            StGnt0, StGnt1: begin
                if (!own_valid || burst_done) begin
                    if (other_valid) begin
                        state_d = own_id ? StGnt0 : StGnt1;
                        cnt_d   = '0;
                        rr_d    = own_id;
                    end else if (own_valid) begin
                        cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            cv_de   <= 1'b0;
            cv_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            cv_de   <= xfer;
            if (xfer) begin
                cv_id_q <= xfer1;
            end
        end
    end

    // Converter input data is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (xfer) begin
            cv_R <= xfer_rgb[RgbRPos*DSIZE +: DSIZE];
            cv_G <= xfer_rgb[RgbGPos*DSIZE +: DSIZE];
            cv_B <= xfer_rgb[RgbBPos*DSIZE +: DSIZE];
        end
    end

    ycc_tag_pipe #(
        .LAT (LAT),
        .W   (2)
    ) u_tag_pipe (
        .clock (clock),
        .clear (reset),
        .din   ({cv_de, cv_id_q}),
        .dout  ({tag_valid, tag_id})
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_id    <= 1'b0;
        end else begin
            out_valid <= tag_valid;
            if (tag_valid) begin
                out_id <= tag_id;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (tag_valid) begin
            out_ycc[YccYPos*DSIZE +: DSIZE]  <= cv_Y;
            out_ycc[YccCbPos*DSIZE +: DSIZE] <= cv_Cb;
            out_ycc[YccCrPos*DSIZE +: DSIZE] <= cv_Cr;
        end
    end

    // Returns of pixels discarded by reset may still arrive; ignore them until the
    // converter has drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= MaskW'(LAT + 1);
            err    <= 1'b0;
        end else if (mask_q != '0) begin
            mask_q <= mask_q - MaskW'(1);
        end else if (tag_valid != cv_de_ret) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ycc_share_arb.sv
// Directed bench: two arbiter instances (BURST=4 and default 16) each with a
// fixed-latency pass-through converter model.
module tb_ycc_share_arb;

    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 3;

    logic clock = 1'b0;
    logic reset;
    logic req0_valid, req1_valid;
    logic [3*DW-1:0] req0_rgb, req1_rgb;
    logic drop_en;

    logic req0_ready, req1_ready, cv_de, cv_de_ret, out_valid, out_id, err;
    logic [DW-1:0] cv_R, cv_G, cv_B, cv_Y, cv_Cb, cv_Cr;
    logic [3*DW-1:0] out_ycc;

    logic req0_ready_b, req1_ready_b, cv_de_b, cv_de_ret_b, out_valid_b, out_id_b, err_b;
    logic [DW-1:0] cv_R_b, cv_G_b, cv_B_b, cv_Y_b, cv_Cb_b, cv_Cr_b;
    logic [3*DW-1:0] out_ycc_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ycc_share_arb #(.DSIZE(DW), .LAT(LAT), .BURST(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rgb(req0_rgb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rgb(req1_rgb),
        .cv_de(cv_de), .cv_R(cv_R), .cv_G(cv_G), .cv_B(cv_B),
        .cv_de_ret(cv_de_ret), .cv_Y(cv_Y), .cv_Cb(cv_Cb), .cv_Cr(cv_Cr),
        .out_valid(out_valid), .out_id(out_id), .out_ycc(out_ycc), .err(err)
    );

    ycc_share_arb #(.DSIZE(DW), .LAT(LAT)) dut16 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready_b), .req0_rgb(req0_rgb),
        .req1_valid(req1_valid), .req1_ready(req1_ready_b), .req1_rgb(req1_rgb),
        .cv_de(cv_de_b), .cv_R(cv_R_b), .cv_G(cv_G_b), .cv_B(cv_B_b),
        .cv_de_ret(cv_de_ret_b), .cv_Y(cv_Y_b), .cv_Cb(cv_Cb_b), .cv_Cr(cv_Cr_b),
        .out_valid(out_valid_b), .out_id(out_id_b), .out_ycc(out_ycc_b), .err(err_b)
    );

    // Converter models: LAT-stage pass-through (Y=R, Cb=G, Cr=B), never reset.
    logic            ma_de [LAT];
    logic [3*DW-1:0] ma_px [LAT];
    logic            mb_de [LAT];
    logic [3*DW-1:0] mb_px [LAT];

    always @(posedge clock) begin
        ma_de[0] <= cv_de & ~drop_en;
        ma_px[0] <= {cv_R, cv_G, cv_B};
        mb_de[0] <= cv_de_b;
        mb_px[0] <= {cv_R_b, cv_G_b, cv_B_b};
        for (int i = 1; i < LAT; i++) begin
            ma_de[i] <= ma_de[i-1];
            ma_px[i] <= ma_px[i-1];
            mb_de[i] <= mb_de[i-1];
            mb_px[i] <= mb_px[i-1];
        end
    end

    assign cv_de_ret             = ma_de[LAT-1];
    assign {cv_Y, cv_Cb, cv_Cr}  = ma_px[LAT-1];
    assign cv_de_ret_b           = mb_de[LAT-1];
    assign {cv_Y_b, cv_Cb_b, cv_Cr_b} = mb_px[LAT-1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({req0_ready, req1_ready, cv_de} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_de: got %b want 000", {req0_ready, req1_ready, cv_de});
        end
        checks++;
        if ({out_valid, out_id, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_out_err: got %b want 000", {out_valid, out_id, err});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({req0_ready, req1_ready, cv_de, out_valid, err} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_idle: got %b want 00000",
                     {req0_ready, req1_ready, cv_de, out_valid, err});
        end
    endtask

    // Both valid continuously from reset: 4 x req0, 4 x req1, ... with no gaps.
    task automatic test_contention();
        logic exp_id;
        req0_rgb = 48'hA000_A001_A002;
        req1_rgb = 48'hB000_B001_B002;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            exp_id = ((k / 4) % 2) == 1;
            checks++;
            if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got r1r0=%b want %b", k,
                         {req1_ready, req0_ready}, {exp_id, ~exp_id});
            end
            tick();
            checks++;
            if (cv_de !== 1'b1) begin
                errors++;
                $display("FAIL contention_cv_de[%0d]: got %b want 1", k, cv_de);
            end
            if (k >= 4) begin
                exp_id = (((k - 4) / 4) % 2) == 1;
                checks++;
                if ({out_valid, out_id} !== {1'b1, exp_id}) begin
                    errors++;
                    $display("FAIL contention_out[%0d]: got v/id=%b want %b", k,
                             {out_valid, out_id}, {1'b1, exp_id});
                end
            end
        end
        drain();
    endtask

    // req0 alone, 3 pixels: results on cycles 5..7 after the first handshake.
    task automatic test_single();
        logic [3*DW-1:0] px [3];
        logic exp_v;
        px[0] = 48'h1111_2222_3333;
        px[1] = 48'h4444_5555_6666;
        px[2] = 48'h7777_8888_9999;
        req0_rgb   = px[0];
        req0_valid = 1'b1;
        tick();
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got ready0=%b want 1", req0_ready);
        end
        tick();
        checks++;
        if ({cv_de, cv_R, cv_G, cv_B} !== {1'b1, 48'h1111_2222_3333}) begin
            errors++;
            $display("FAIL single_cv: got %b %h%h%h want 1 111122223333", cv_de, cv_R, cv_G,
                     cv_B);
        end
        req0_rgb = px[1];
        tick();
        req0_rgb = px[2];
        tick();
        req0_valid = 1'b0;
        for (int c = 3; c <= 9; c++) begin
            exp_v = (c >= 5) && (c <= 7);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL single_valid[c%0d]: got %b want %b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ({out_id, out_ycc} !== {1'b0, px[c-5]}) begin
                    errors++;
                    $display("FAIL single_data[c%0d]: got id=%b ycc=%h want 0 %h", c, out_id,
                             out_ycc, px[c-5]);
                end
            end
            if (c == 4) begin
                checks++;
                if ({cv_de, cv_R} !== {1'b0, 16'h7777}) begin
                    errors++;
                    $display("FAIL single_cv_hold: got %b %h want 0 7777", cv_de, cv_R);
                end
            end
            if (c == 9) begin
                checks++;
                if (out_ycc !== px[2]) begin
                    errors++;
                    $display("FAIL single_ycc_hold: got %h want %h", out_ycc, px[2]);
                end
            end
            tick();
        end
        drain();
    endtask

    // req1 (favoured after req0 was served) sends 2 then drops; req0 takes over and
    // req1 then gets a full fresh burst of 4.
    task automatic test_early_release();
        logic exp_id;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_rr_pick: got ready1=%b want 1", req1_ready);
        end
        tick();
        tick();
        req1_valid = 1'b0;
        tick();
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL early_switch: got r1r0=%b want 01", {req1_ready, req0_ready});
        end
        req1_valid = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            exp_id = ((k / 4) % 2) == 1;
            checks++;
            if ({req1_ready, req0_ready} !== {exp_id, ~exp_id}) begin
                errors++;
                $display("FAIL early_burst[%0d]: got r1r0=%b want %b", k,
                         {req1_ready, req0_ready}, {exp_id, ~exp_id});
            end
            tick();
        end
        drain();
    endtask

    task automatic test_burst_exhaust();
        int n4 = 0;
        int n16 = 0;
        req0_valid = 1'b1;
        tick();
        for (int k = 0; k < 40; k++) begin
            if (req0_ready) n4++;
            if (req0_ready_b) n16++;
            tick();
        end
        checks++;
        if (n16 !== 40) begin
            errors++;
            $display("FAIL exhaust_count16: got %0d want 40", n16);
        end
        checks++;
        if (n4 !== 40) begin
            errors++;
            $display("FAIL exhaust_count4: got %0d want 40", n4);
        end
        checks++;
        if ({req0_ready_b, req0_ready} !== 2'b11) begin
            errors++;
            $display("FAIL exhaust_state: got %b want 11", {req0_ready_b, req0_ready});
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        req0_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (cv_de !== 1'b0) begin
            errors++;
            $display("FAIL midrst_cv_de: got %b want 0", cv_de);
        end
        for (int c = 0; c < 12; c++) begin
            checks++;
            if ({out_valid, err} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_quiet[%0d]: got valid/err=%b want 00", c,
                         {out_valid, err});
            end
            tick();
        end
    endtask

    // One returned cv_de is suppressed: err rises with the orphaned tag and sticks.
    task automatic test_fault();
        logic exp_e;
        req0_rgb   = 48'hC0C0_D0D0_E0E0;
        req0_valid = 1'b1;
        tick();
        tick();
        req0_valid = 1'b0;
        drop_en    = 1'b1;
        tick();
        drop_en    = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            exp_e = (c >= 5);
            checks++;
            if (err !== exp_e) begin
                errors++;
                $display("FAIL fault_err[c%0d]: got %b want %b", c, err, exp_e);
            end
            if (c == 5) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL fault_valid: got %b want 1", out_valid);
                end
            end
            tick();
        end
        checks++;
        if (err_b !== 1'b0) begin
            errors++;
            $display("FAIL fault_other_inst: got %b want 0", err_b);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got %b want 0", err);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_rgb   = '0;
        req1_rgb   = '0;
        drop_en    = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_early_release();
        test_burst_exhaust();
        test_reset_midstream();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
